nibble_packer: RTL

- Downstream stage for the 4-bit mode-controlled register/counter block. Takes its Q output on the D input here.
- Samples the 4-bit stream on an enable strobe and packs NIBBLES consecutive samples, MSB-first, into one word.
- Presents each word through a one-entry valid/ready output register. Detects and flags overflow when backpressure would lose a word.

---
 rtl/nibble_packer_pkg.sv | 10 +
 rtl/nibble_acc.sv | 33 +++
 rtl/nibble_packer.sv | 57 +++++
 3 files changed

// File: rtl/nibble_packer_pkg.sv
// rtl/nibble_packer_pkg.sv - shared constants for the nibble packer
package nibble_packer_pkg;

  localparam int NIB_W  = 4;
  localparam int FILL_W = 3;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

endpackage

// File: rtl/nibble_acc.sv
// rtl/nibble_acc.sv - shift accumulator and fill counter producing a packed word
module nibble_acc
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int WW      = 4 * NIBBLES
) (
  input  logic              clk,
  input  logic              r,
  input  logic              en,
  input  logic [NIB_W-1:0]  d,
  output logic [FILL_W-1:0] fill,
  output logic              done,
  output logic [WW-1:0]     word
);

  // Only the oldest NIBBLES-1 nibbles need storage; the last one arrives on d.
  logic [WW-NIB_W-1:0] acc;

  assign word = {acc, d};
  assign done = en && (fill == FILL_W'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (r) begin
      acc  <= '0;
      fill <= '0;
    end else if (en) begin
      acc  <= word[WW-NIB_W-1:0];
      fill <= done ? '0 : fill + FILL_W'(1);
    end
  end

endmodule

// File: rtl/nibble_packer.sv
// rtl/nibble_packer.sv - packs 4-bit samples into words behind a one-entry output register
module nibble_packer
  import nibble_packer_pkg::*;
#(
  parameter int NIBBLES = 4,
  parameter int WW      = 4 * NIBBLES
) (
  input  logic              clk,
  input  logic              r,
  input  logic              en,
  input  logic [NIB_W-1:0]  D,
  input  logic              ready,
  output logic              valid,
  output logic [WW-1:0]     W,
  output logic [FILL_W-1:0] fill,
  output logic              ovf
);

  logic          state;
  logic          done;
  logic [WW-1:0] word;

  nibble_acc #(
    .NIBBLES (NIBBLES),
    .WW      (WW)
  ) u_acc (
    .clk  (clk),
    .r    (r),
    .en   (en),
    .d    (D),
    .fill (fill),
    .done (done),
    .word (word)
  );

  assign valid = (state == ST_FULL);

  // A completing word replaces W when the slot is free or being drained this edge;
  // otherwise it is lost and the loss is remembered in ovf.
  always_ff @(posedge clk) begin
    if (r) begin
      state <= ST_EMPTY;
      W     <= '0;
      ovf   <= 1'b0;
    end else if (done) begin
      if (state == ST_EMPTY || ready) begin
        state <= ST_FULL;
        W     <= word;
      end else begin
        ovf <= 1'b1;
      end
    end else if (state == ST_FULL && ready) begin
      state <= ST_EMPTY;
    end
  end

endmodule
